// File: rtl/dda_voxel_stepper.sv
// dda_voxel_stepper: per-ray DDA traversal, one voxel per step.
// Voxels go out over valid/ready; ends on hit, grid exit or step limit.
module dda_voxel_stepper #(
   parameter int W = 32,
   parameter int CW = 5,
   parameter int MAX_STEPS = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             load,
   input  logic [CW-1:0]                    init_x,
   input  logic [CW-1:0]                    init_y,
   input  logic [CW-1:0]                    init_z,
   input  logic [W-1:0]                     init_tmax_x,
   input  logic [W-1:0]                     init_tmax_y,
   input  logic [W-1:0]                     init_tmax_z,
   input  logic [W-1:0]                     tdelta_x,
   input  logic [W-1:0]                     tdelta_y,
   input  logic [W-1:0]                     tdelta_z,
   input  logic [2:0]                       step_neg,
   output logic [W-1:0]                     tmax_x,
   output logic [W-1:0]                     tmax_y,
   output logic [W-1:0]                     tmax_z,
   input  logic [2:0]                       step_mask,
   output logic                             vox_valid,
   input  logic                             vox_ready,
   input  logic                             vox_hit,
   output logic [CW-1:0]                    vox_x,
   output logic [CW-1:0]                    vox_y,
   output logic [CW-1:0]                    vox_z,
   output logic                             busy,
   output logic                             done,
   output logic [1:0]                       exit_reason,
   output logic [$clog2(MAX_STEPS+1)-1:0]   step_count
);

   localparam int SCW = $clog2(MAX_STEPS+1);
   localparam logic [SCW-1:0] LIMIT = SCW'(MAX_STEPS);

   typedef enum logic [1:0] {IDLE, EMIT, STEP, DONE} state_t;

   state_t         state;
   logic [W-1:0]   td_x, td_y, td_z;
   logic [2:0]     neg;
   logic [2:0]     sel;
   logic           oob;
   logic [SCW-1:0] cnt_nx;

   function automatic logic [W-1:0] sat_add(
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[W] ? '1 : s[W-1:0];
   endfunction

   function automatic logic [CW-1:0] move(
      input logic [CW-1:0] c,
      input logic          n
   );
      return n ? c - 1'b1 : c + 1'b1;
   endfunction

   function automatic logic at_edge(
      input logic [CW-1:0] c,
      input logic          n
   );
      return n ? (c == '0) : (c == '1);
   endfunction

   // Axis selection (empty mask means x) and grid-exit detection.
   always_comb begin
      sel = (step_mask == 3'b000) ? 3'b001 : step_mask;
      oob = (sel[0] & at_edge(vox_x, neg[0]))
          | (sel[1] & at_edge(vox_y, neg[1]))
          | (sel[2] & at_edge(vox_z, neg[2]));
      cnt_nx = step_count + 1'b1;
   end

   // Traversal FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         vox_x       <= '0;
         vox_y       <= '0;
         vox_z       <= '0;
         tmax_x      <= '0;
         tmax_y      <= '0;
         tmax_z      <= '0;
         td_x        <= '0;
         td_y        <= '0;
         td_z        <= '0;
         neg         <= '0;
         vox_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         exit_reason <= 2'b00;
         step_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  vox_x       <= init_x;
                  vox_y       <= init_y;
                  vox_z       <= init_z;
                  tmax_x      <= init_tmax_x;
                  tmax_y      <= init_tmax_y;
                  tmax_z      <= init_tmax_z;
                  td_x        <= tdelta_x;
                  td_y        <= tdelta_y;
                  td_z        <= tdelta_z;
                  neg         <= step_neg;
                  step_count  <= '0;
                  exit_reason <= 2'b00;
                  vox_valid   <= 1'b1;
                  busy        <= 1'b1;
                  state       <= EMIT;
               end
            end
            EMIT: begin
               if (vox_ready) begin
                  vox_valid  <= 1'b0;
                  step_count <= cnt_nx;
                  if (vox_hit) begin
                     exit_reason <= 2'b01;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else if (cnt_nx == LIMIT) begin
                     exit_reason <= 2'b11;
                     done        <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= STEP;
                  end
               end
            end
            STEP: begin
               if (oob) begin
                  exit_reason <= 2'b10;
                  done        <= 1'b1;
                  state       <= DONE;
               end else begin
                  if (sel[0]) begin
                     vox_x  <= move(vox_x, neg[0]);
                     tmax_x <= sat_add(tmax_x, td_x);
                  end
                  if (sel[1]) begin
                     vox_y  <= move(vox_y, neg[1]);
                     tmax_y <= sat_add(tmax_y, td_y);
                  end
                  if (sel[2]) begin
                     vox_z  <= move(vox_z, neg[2]);
                     tmax_z <= sat_add(tmax_z, td_z);
                  end
                  vox_valid <= 1'b1;
                  state     <= EMIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dda_voxel_stepper.sv
// tb_dda_voxel_stepper: directed and random rays against a
// transaction-level DDA reference model.
module tb_dda_voxel_stepper;

   localparam int W = 32;
   localparam int CW = 5;
   localparam int MAX_STEPS = 64;
   localparam int SCW = $clog2(MAX_STEPS+1);
   localparam longint TMAXV = longint'((64'd1 << W) - 1);
   localparam int CMAXV = (1 << CW) - 1;

   logic           clk;
   logic           rst_n;
   logic           load;
   logic [CW-1:0]  init_x, init_y, init_z;
   logic [W-1:0]   init_tmax_x, init_tmax_y, init_tmax_z;
   logic [W-1:0]   tdelta_x, tdelta_y, tdelta_z;
   logic [2:0]     step_neg;
   logic [W-1:0]   tmax_x, tmax_y, tmax_z;
   logic [2:0]     step_mask;
   logic           vox_valid;
   logic           vox_ready;
   logic           vox_hit;
   logic [CW-1:0]  vox_x, vox_y, vox_z;
   logic           busy;
   logic           done;
   logic [1:0]     exit_reason;
   logic [SCW-1:0] step_count;

   int n_checks = 0;
   int n_errors = 0;

   logic [127:0] exp_q[$];
   logic [127:0] got_q[$];
   int           exp_reason;
   int           exp_cnt;
   logic [W-1:0] tmin;

   dda_voxel_stepper #(.W(W), .CW(CW), .MAX_STEPS(MAX_STEPS)) dut (
      .clk(clk), .rst_n(rst_n), .load(load),
      .init_x(init_x), .init_y(init_y), .init_z(init_z),
      .init_tmax_x(init_tmax_x), .init_tmax_y(init_tmax_y),
      .init_tmax_z(init_tmax_z),
      .tdelta_x(tdelta_x), .tdelta_y(tdelta_y), .tdelta_z(tdelta_z),
      .step_neg(step_neg),
      .tmax_x(tmax_x), .tmax_y(tmax_y), .tmax_z(tmax_z),
      .step_mask(step_mask),
      .vox_valid(vox_valid), .vox_ready(vox_ready), .vox_hit(vox_hit),
      .vox_x(vox_x), .vox_y(vox_y), .vox_z(vox_z),
      .busy(busy), .done(done), .exit_reason(exit_reason),
      .step_count(step_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Min-axis selector: every axis equal to the minimum tMax is flagged.
   always_comb begin
      tmin = tmax_x;
      if (tmax_y < tmin) tmin = tmax_y;
      if (tmax_z < tmin) tmin = tmax_z;
      step_mask = {tmax_z == tmin, tmax_y == tmin, tmax_x == tmin};
   end

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] pack(input int x, input int y,
      input int z, input longint tx, input longint ty, input longint tz);
      return 128'({CW'(x), CW'(y), CW'(z), W'(tx), W'(ty), W'(tz)});
   endfunction

   function automatic logic [127:0] obs();
      return 128'({vox_x, vox_y, vox_z, tmax_x, tmax_y, tmax_z});
   endfunction

   // Reference: list of voxels emitted, exit reason and count.
   task automatic model_ray(input int x0, input int y0, input int z0,
      input longint t0x, input longint t0y, input longint t0z,
      input longint dx, input longint dy, input longint dz,
      input logic [2:0] ng, input int hit_at);
      int     p[3];
      longint t[3];
      longint d[3];
      longint mn;
      bit     mv[3];
      bit     out;
      bit     fin;
      int     n;
      int     np;
      p = '{x0, y0, z0};
      t = '{t0x, t0y, t0z};
      d = '{dx, dy, dz};
      exp_q.delete();
      exp_reason = 0;
      n = 0;
      fin = 0;
      for (int it = 0; it < 1000 && !fin; it++) begin
         exp_q.push_back(pack(p[0], p[1], p[2], t[0], t[1], t[2]));
         n++;
         if (n == hit_at) begin
            exp_reason = 1;
            fin = 1;
         end else if (n == MAX_STEPS) begin
            exp_reason = 3;
            fin = 1;
         end else begin
            mn = t[0];
            for (int a = 1; a < 3; a++) if (t[a] < mn) mn = t[a];
            out = 0;
            for (int a = 0; a < 3; a++) begin
               mv[a] = (t[a] == mn);
               np = ng[a] ? p[a] - 1 : p[a] + 1;
               if (mv[a] && (np < 0 || np > CMAXV)) out = 1;
            end
            if (out) begin
               exp_reason = 2;
               fin = 1;
            end else begin
               for (int a = 0; a < 3; a++) begin
                  if (mv[a]) begin
                     p[a] = ng[a] ? p[a] - 1 : p[a] + 1;
                     t[a] = (t[a] + d[a] > TMAXV) ? TMAXV : t[a] + d[a];
                  end
               end
            end
         end
      end
      exp_cnt = n;
   endtask

   task automatic garbage_inputs();
      init_x = CW'($urandom);
      init_y = CW'($urandom);
      init_z = CW'($urandom);
      init_tmax_x = W'($urandom);
      init_tmax_y = W'($urandom);
      init_tmax_z = W'($urandom);
      tdelta_x = W'($urandom);
      tdelta_y = W'($urandom);
      tdelta_z = W'($urandom);
      step_neg = 3'($urandom);
   endtask

   // rmode: 0 ready always, 1 random ready, 2 ready after 5 stall cycles
   task automatic run_ray(input int x0, input int y0, input int z0,
      input longint t0x, input longint t0y, input longint t0z,
      input longint dx, input longint dy, input longint dz,
      input logic [2:0] ng, input int hit_at, input int rmode);
      int           idx;
      int           hs_age;
      int           stall;
      bit           fin;
      bit           hs;
      bit           prev_valid;
      bit           prev_hs;
      logic [127:0] prev;
      model_ray(x0, y0, z0, t0x, t0y, t0z, dx, dy, dz, ng, hit_at);
      got_q.delete();
      @(negedge clk);
      load = 1'b1;
      init_x = CW'(x0);
      init_y = CW'(y0);
      init_z = CW'(z0);
      init_tmax_x = W'(t0x);
      init_tmax_y = W'(t0y);
      init_tmax_z = W'(t0z);
      tdelta_x = W'(dx);
      tdelta_y = W'(dy);
      tdelta_z = W'(dz);
      step_neg = ng;
      vox_ready = 1'b0;
      vox_hit = 1'b0;
      @(negedge clk);
      load = 1'b0;
      chk("first_valid", 128'(vox_valid), 128'(1));
      idx = 0;
      hs_age = 100;
      stall = 0;
      fin = 0;
      prev_valid = 0;
      prev_hs = 0;
      prev = '0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         if (done) begin
            chk("exit_reason", 128'(exit_reason), 128'(exp_reason));
            chk("step_count", 128'(step_count), 128'(exp_cnt));
            chk("handshakes", 128'(idx), 128'(exp_cnt));
            chk("final_vox", obs(), exp_q[$]);
            chk("done_busy", 128'(busy), 128'(1));
            load = 1'($urandom);
            garbage_inputs();
            vox_ready = 1'($urandom);
            @(negedge clk);
            load = 1'b0;
            chk("done_pulse", 128'(done), 128'(0));
            chk("idle_busy", 128'(busy), 128'(0));
            chk("hold_reason", 128'(exit_reason), 128'(exp_reason));
            chk("hold_vox", obs(), exp_q[$]);
            fin = 1;
         end else begin
            chk("busy", 128'(busy), 128'(1));
            if (hs_age == 1) chk("valid_drop", 128'(vox_valid), 128'(0));
            if (hs_age == 2) chk("valid_back", 128'(vox_valid), 128'(1));
            if (vox_valid && prev_valid && !prev_hs)
               chk("stall_hold", obs(), prev);
            case (rmode)
               0: vox_ready = 1'b1;
               1: vox_ready = 1'($urandom);
               default: vox_ready = vox_valid ? (stall >= 5) : 1'($urandom);
            endcase
            if (vox_valid) stall++;
            hs = vox_valid && vox_ready;
            if (hs) begin
               vox_hit = (idx + 1 == hit_at);
               if (idx < exp_q.size()) chk("voxel", obs(), exp_q[idx]);
               else chk("extra_voxel", 128'(idx), 128'(exp_q.size()));
               got_q.push_back(obs());
               idx++;
               hs_age = 0;
               stall = 0;
            end else begin
               vox_hit = 1'($urandom);
            end
            load = ($urandom_range(0, 7) == 0);
            garbage_inputs();
            prev = obs();
            prev_valid = vox_valid;
            prev_hs = hs;
            hs_age++;
            @(negedge clk);
         end
      end
      if (!fin) chk("timeout", 128'(0), 128'(1));
      load = 1'b0;
      vox_ready = 1'b0;
      vox_hit = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_vox"}, obs(), '0);
      chk({tag, "_ctl"},
          128'({vox_valid, busy, done, exit_reason, step_count}), '0);
   endtask

   function automatic logic [127:0] got_at(input int i);
      return (got_q.size() > i) ? got_q[i] : '1;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      load = 1'b0;
      vox_ready = 1'b0;
      vox_hit = 1'b0;
      garbage_inputs();
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("idle");

      // single-axis walk to the +x wall
      run_ray(0, 0, 0, 10, 1000, 1000, 10, 100, 100, 3'b000, 0, 0);
      chk("t1_v1", got_at(1), pack(1, 0, 0, 20, 1000, 1000));
      chk("t1_reason", 128'(exit_reason), 128'(2));
      chk("t1_count", 128'(step_count), 128'(32));
      chk("t1_vx", 128'(vox_x), 128'(31));

      // tie / diagonal steps
      run_ray(3, 3, 3, 5, 5, 9, 4, 4, 4, 3'b011, 3, 1);
      chk("t2_v1", got_at(1), pack(2, 2, 3, 9, 9, 9));
      chk("t2_v2", got_at(2), pack(1, 1, 4, 13, 13, 13));

      // hit on second voxel under back-pressure
      run_ray(10, 10, 10, 100, 200, 300, 50, 50, 50, 3'b000, 2, 2);
      chk("t3_reason", 128'(exit_reason), 128'(1));
      chk("t3_count", 128'(step_count), 128'(2));

      // step limit on a long three-axis path
      run_ray(0, 0, 0, 1, 2, 3, 3, 3, 3, 3'b000, 0, 0);
      chk("t4_reason", 128'(exit_reason), 128'(3));
      chk("t4_count", 128'(step_count), 128'(MAX_STEPS));

      // tMax saturation
      run_ray(0, 5, 5, TMAXV - 2, TMAXV, TMAXV, 8, 1, 1, 3'b000, 2, 0);
      chk("t5_sat", got_at(1), pack(1, 5, 5, TMAXV, TMAXV, TMAXV));

      // reset in the middle of a ray
      @(negedge clk);
      load = 1'b1;
      init_x = 5'd4;
      init_y = 5'd4;
      init_z = 5'd4;
      init_tmax_x = 32'd7;
      init_tmax_y = 32'd8;
      init_tmax_z = 32'd9;
      vox_ready = 1'b0;
      @(negedge clk);
      load = 1'b0;
      chk("mr_valid", 128'(vox_valid), 128'(1));
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_zero("midreset");
      @(negedge clk);
      chk("mr_nodone", 128'(done), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk_zero("postreset");
      run_ray(30, 1, 16, 3, 6, 12, 9, 5, 2, 3'b010, 0, 1);

      // random rays
      for (int r = 0; r < 30; r++) begin
         longint t0[3];
         longint d0[3];
         int     hit;
         for (int a = 0; a < 3; a++) begin
            t0[a] = longint'($urandom_range(0, 2000));
            if ($urandom_range(0, 3) == 0)
               t0[a] = TMAXV - longint'($urandom_range(0, 1000));
            d0[a] = longint'($urandom_range(0, 700));
         end
         hit = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 70));
         run_ray(int'($urandom_range(0, CMAXV)),
                 int'($urandom_range(0, CMAXV)),
                 int'($urandom_range(0, CMAXV)),
                 t0[0], t0[1], t0[2], d0[0], d0[1], d0[2],
                 3'($urandom), hit, int'($urandom_range(0, 2)));
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
